// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_write_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  function automatic int calc_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // One extra bit so the counter can hold MAX_BURST itself.
  function automatic int calc_cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side handshake plus FIFO write port seen by the arbiter.
interface fifo_write_arbiter_if
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full_ind;
  logic                          fifo_wenable;
  logic [DATA_WIDTH-1:0]         fifo_wdata;

  modport master (
    output req_valid, req_last, req_data, full_ind,
    input  req_ready, fifo_wenable, fifo_wdata
  );

  modport slave (
    input  req_valid, req_last, req_data, full_ind,
    output req_ready, fifo_wenable, fifo_wdata
  );
endinterface

// File: rtl/fifo_write_arbiter_picker.sv
// Round-robin pick: first set request strictly after 'last', wrapping around.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               any,
  output logic [ID_W-1:0]    idx
);
  logic [2*NUM_REQ-1:0] masked;

  assign any = |req;

  // Doubled request vector with everything up to and including 'last' masked off.
  always_comb begin
    for (int j = 0; j < 2*NUM_REQ; j++) begin
      masked[j] = req[j % NUM_REQ] && (j > int'(last));
    end
  end

  always_comb begin
    idx = '0;
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (masked[j]) idx = ID_W'(j % NUM_REQ);
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between NUM_REQ requesters, round robin, bursts capped at MAX_BURST.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int ID_W       = calc_id_w(NUM_REQ),
  parameter int CNT_W      = calc_cnt_w(MAX_BURST)
) (
  input  logic                 clk_in,
  input  logic                 areset_b,
  fifo_write_arbiter_if.slave  bus,
  input  logic                 flush,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic [CNT_W-1:0]     beat_cnt
);
  arb_state_e            state, state_n;
  logic [ID_W-1:0]       grant_id_n, last_grant, last_grant_n, pick_idx;
  logic [CNT_W-1:0]      beat_cnt_n;
  logic                  pick_any, accept_ok, beat, sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req  (bus.req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign grant_valid = (state == ARB_GRANT);
  assign accept_ok   = grant_valid && !bus.full_ind && !flush;

  always_comb begin
    bus.req_ready = '0;
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        bus.req_ready[i] = accept_ok;
        sel_valid        = bus.req_valid[i];
        sel_last         = bus.req_last[i];
        sel_data         = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign beat             = accept_ok && sel_valid;
  assign bus.fifo_wenable = beat;
  assign bus.fifo_wdata   = beat ? sel_data : '0;

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ-1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_id_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    grant_id_n   = grant_id;
    last_grant_n = last_grant;
    beat_cnt_n   = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (!flush && pick_any) begin
          state_n      = ARB_GRANT;
          grant_id_n   = pick_idx;
          last_grant_n = pick_idx;
        end
      end
      ARB_GRANT: begin
        if (flush) begin
          state_n = ARB_IDLE;
        end else if (beat) begin
          beat_cnt_n = beat_cnt + 1'b1;
          if (sel_last || beat_cnt == CNT_W'(MAX_BURST-1)) state_n = ARB_IDLE;
        end else if (!sel_valid) begin
          // Requester withdrew mid-grant; full_ind alone never releases.
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
    if (state_n == ARB_IDLE) beat_cnt_n = '0;
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based arbitration model.
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_W       = calc_id_w(NUM_REQ);
  localparam int CNT_W      = calc_cnt_w(MAX_BURST);

  logic clk_in   = 1'b0;
  logic areset_b = 1'b0;
  logic flush    = 1'b0;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [CNT_W-1:0]  beat_cnt;

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_in      (clk_in),
    .areset_b    (areset_b),
    .bus         (bus),
    .flush       (flush),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .beat_cnt    (beat_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic                  l;
  } beat_t;

  beat_t                 q [NUM_REQ][$];
  logic [NUM_REQ-1:0]    pause;
  logic [DATA_WIDTH-1:0] wlog [$];
  int                    glog [$];
  logic                  prev_gv;
  int                    m_gnt, m_last, m_cnt;
  int                    n_checks, n_fail;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt  = -1;
    m_last = NUM_REQ - 1;
    m_cnt  = 0;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += q[i].size();
    return s;
  endfunction

  task automatic drive_inputs();
    logic [NUM_REQ-1:0]            v, l;
    logic [NUM_REQ*DATA_WIDTH-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q[i].size() > 0 && !pause[i]) begin
        v[i] = 1'b1;
        l[i] = q[i][0].l;
        d[i*DATA_WIDTH +: DATA_WIDTH] = q[i][0].d;
      end else begin
        d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic push_burst(input int r, input int len, input int last_at);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = DATA_WIDTH'($urandom);
      b.l = (k == last_at);
      q[r].push_back(b);
    end
  endtask

  // One clock: check outputs at negedge, advance the model at posedge, redrive.
  task automatic cycle();
    logic                  exp_gv, exp_beat, last_b;
    logic [NUM_REQ-1:0]    exp_rdy;
    logic [DATA_WIDTH-1:0] exp_wd;
    int                    g;
    @(negedge clk_in);
    exp_gv   = (m_gnt >= 0);
    exp_rdy  = '0;
    exp_beat = 1'b0;
    exp_wd   = '0;
    last_b   = 1'b0;
    if (exp_gv && !bus.full_ind && !flush) exp_rdy[m_gnt] = 1'b1;
    if (exp_gv && exp_rdy[m_gnt] && bus.req_valid[m_gnt]) begin
      exp_beat = 1'b1;
      exp_wd   = q[m_gnt][0].d;
      last_b   = q[m_gnt][0].l;
    end
    chk_val("grant_valid", grant_valid, exp_gv);
    if (exp_gv) chk_val("grant_id", grant_id, m_gnt);
    chk_val("beat_cnt", beat_cnt, m_cnt);
    chk_val("req_ready", bus.req_ready, exp_rdy);
    chk_val("fifo_wenable", bus.fifo_wenable, exp_beat);
    chk_val("fifo_wdata", bus.fifo_wdata, exp_wd);
    chk_val("write_while_full", bus.fifo_wenable && bus.full_ind, 0);
    if (bus.fifo_wenable) wlog.push_back(bus.fifo_wdata);
    if (grant_valid && !prev_gv) glog.push_back(int'(grant_id));
    prev_gv = grant_valid;

    @(posedge clk_in);
    g = m_gnt;
    if (m_gnt < 0) begin
      if (!flush && bus.req_valid != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_last + k) % NUM_REQ;
          if (bus.req_valid[c]) begin
            m_gnt = c; m_last = c; m_cnt = 0;
            break;
          end
        end
      end
    end else if (flush) begin
      m_gnt = -1; m_cnt = 0;
    end else if (exp_beat) begin
      m_cnt++;
      if (last_b || m_cnt == MAX_BURST) begin m_gnt = -1; m_cnt = 0; end
    end else if (!bus.req_valid[m_gnt]) begin
      m_gnt = -1; m_cnt = 0;
    end
    if (exp_beat) void'(q[g].pop_front());
    #1;
    drive_inputs();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((pending() > 0 || m_gnt >= 0) && n < max_cycles);
    chk_val("drain", pending(), 0);
  endtask

  task automatic do_reset();
    areset_b     = 1'b0;
    flush        = 1'b0;
    bus.full_ind = 1'b0;
    pause        = '0;
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    drive_inputs();
    model_reset();
    prev_gv = 1'b0;
    @(negedge clk_in);
    chk_val("rst_grant_valid", grant_valid, 0);
    chk_val("rst_grant_id", grant_id, 0);
    chk_val("rst_beat_cnt", beat_cnt, 0);
    chk_val("rst_req_ready", bus.req_ready, 0);
    chk_val("rst_wenable", bus.fifo_wenable, 0);
    @(posedge clk_in);
    #2 areset_b = 1'b1;
    wlog.delete();
    glog.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    beat_t b;
    n_checks = 0;
    n_fail   = 0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.full_ind  = 1'b0;
    pause         = '0;

    // Single 3-beat burst from requester 1.
    do_reset();
    b.d = 8'hA1; b.l = 1'b0; q[1].push_back(b);
    b.d = 8'hB2; b.l = 1'b0; q[1].push_back(b);
    b.d = 8'hC3; b.l = 1'b1; q[1].push_back(b);
    drive_inputs();
    run_until_idle(20);
    chk_val("t2_writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk_val("t2_w0", wlog[0], 8'hA1);
      chk_val("t2_w1", wlog[1], 8'hB2);
      chk_val("t2_w2", wlog[2], 8'hC3);
    end
    chk_val("t2_grants", glog.size(), 1);
    if (glog.size() == 1) chk_val("t2_gid", glog[0], 1);

    // Round robin: every requester has two single-beat bursts.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      push_burst(i, 1, 0);
      push_burst(i, 1, 0);
    end
    drive_inputs();
    run_until_idle(40);
    chk_val("t3_grants", glog.size(), 8);
    for (int k = 0; k < 5 && k < glog.size(); k++) chk_val($sformatf("t3_order%0d", k), glog[k], k % NUM_REQ);
    chk_val("t3_writes", wlog.size(), 8);

    // Burst cap: req2 streams 6 beats, req0 joins once req2 holds the grant.
    do_reset();
    push_burst(2, 6, 5);
    drive_inputs();
    cycle();
    push_burst(0, 1, 0);
    drive_inputs();
    run_until_idle(40);
    chk_val("t4_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk_val("t4_g0", glog[0], 2);
      chk_val("t4_g1", glog[1], 0);
      chk_val("t4_g2", glog[2], 2);
    end
    chk_val("t4_writes", wlog.size(), 7);

    // Backpressure for 3 cycles after beat 2 of 4.
    do_reset();
    push_burst(1, 4, 3);
    drive_inputs();
    for (int n = 0; n < 10 && wlog.size() < 2; n++) cycle();
    bus.full_ind = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk_val("t5_hold_cnt", beat_cnt, 2);
      chk_val("t5_ready", bus.req_ready, 0);
      chk_val("t5_grant_held", grant_valid, 1);
    end
    bus.full_ind = 1'b0;
    run_until_idle(20);
    chk_val("t5_writes", wlog.size(), 4);

    // Flush during beat 2 of req3.
    do_reset();
    push_burst(3, 4, 3);
    drive_inputs();
    for (int n = 0; n < 10 && wlog.size() < 1; n++) cycle();
    flush = 1'b1;
    nw = wlog.size();
    for (int n = 0; n < 3; n++) cycle();
    chk_val("t6_no_write", wlog.size(), nw);
    chk_val("t6_idle", grant_valid, 0);
    flush = 1'b0;
    run_until_idle(20);
    chk_val("t6_writes", wlog.size(), 4);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    push_burst(0, 4, 3);
    drive_inputs();
    for (int n = 0; n < 10 && wlog.size() < 2; n++) cycle();
    @(negedge clk_in);
    #1 areset_b = 1'b0;
    #1;
    chk_val("arst_grant_valid", grant_valid, 0);
    chk_val("arst_req_ready", bus.req_ready, 0);
    chk_val("arst_wenable", bus.fifo_wenable, 0);
    chk_val("arst_beat_cnt", beat_cnt, 0);
    do_reset();

    // Randomized traffic with backpressure, flushes and withdrawn requests.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r, len;
        r   = $urandom_range(0, NUM_REQ-1);
        len = $urandom_range(1, 6);
        if (q[r].size() < 8) push_burst(r, len, ($urandom_range(0, 4) == 0) ? -1 : len - 1);
      end
      bus.full_ind = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_REQ; i++) pause[i] = ($urandom_range(0, 9) == 0);
      drive_inputs();
      cycle();
    end
    bus.full_ind = 1'b0;
    flush        = 1'b0;
    pause        = '0;
    drive_inputs();
    run_until_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
